// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage sitting directly after execute.
// Registers the EX->MEM bus under the shared stall vector, selects and
// extends load data from the data SRAM, and holds SRAM read data steady
// while the stage is stalled. Drives the MEM->WB and MEM->ID buses.
// Optional build macro: MEM_ADDR_ERR_EN adds the mem_addr_err output,
// which flags misaligned halfword/word loads and suppresses their rf_we.

module mem_stage #(
   parameter int EX_TO_MEM_WD = 148,
   parameter int MEM_TO_WB_WD = 136,
   parameter int MEM_TO_ID_WD = 104,
   parameter int STALL_WD     = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [STALL_WD-1:0]     stall,
   input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   input  logic [1:0]              ex_addr_lo,
   input  logic [31:0]             data_sram_rdata,
`ifdef MEM_ADDR_ERR_EN
   output logic                    mem_addr_err,
`endif
   output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
   output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus
);

   // Load opcodes carried in the ls_op field
   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;

   // Stall vector positions for this stage and the one after it
   localparam int STALL_MEM = 3;
   localparam int STALL_WB  = 4;

   // Pipeline registers
   logic [EX_TO_MEM_WD-1:0] bus_r;
   logic [1:0]              addr_lo_r;

   // Read-data hold buffer
   logic [31:0] hold_data;
   logic        hold_vld;

   // Fields unpacked from the registered EX->MEM bus
   logic [31:0] pc;
   logic        sram_en;
   logic [3:0]  sram_wen;
   logic        sel_rf_res;
   logic        hi_we;
   logic        lo_we;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [5:0]  ls_op;
   logic [31:0] ex_result;
   logic [31:0] hi;
   logic [31:0] lo;

   // Derived control and data
   logic        mem_stop;
   logic        wb_stop;
   logic        take_bubble;
   logic        take_input;
   logic        is_load;
   logic [31:0] rdata_sel;
   logic [31:0] load_data;
   logic [31:0] rf_wdata;
   logic        rf_we_out;
   logic        unused_ok;

   assign {pc, sram_en, sram_wen, sel_rf_res, hi_we, lo_we, rf_we,
           rf_waddr, ls_op, ex_result, hi, lo} = bus_r;

   // The SRAM strobes are consumed upstream; only the load result matters
   // here, and the other stall bits belong to other stages.
   assign unused_ok = &{1'b0, sram_en, sram_wen,
                        stall[STALL_WD-1:STALL_WB+1], stall[STALL_MEM-1:0]};

   assign mem_stop    = stall[STALL_MEM];
   assign wb_stop     = stall[STALL_WB];
   assign take_bubble = mem_stop && !wb_stop;
   assign take_input  = !mem_stop;

   // Pipeline register: reset, then bubble, then load, otherwise hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_r     <= '0;
         addr_lo_r <= 2'b00;
      end else if (take_bubble) begin
         bus_r     <= '0;
         addr_lo_r <= 2'b00;
      end else if (take_input) begin
         bus_r     <= ex_to_mem_bus;
         addr_lo_r <= ex_addr_lo;
      end
   end

   // Recognise the five load opcodes; everything else is a non-load
   always_comb begin
      is_load = 1'b0;
      case (ls_op)
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load = 1'b1;
         default:                             is_load = 1'b0;
      endcase
   end

   // Capture SRAM data on the first stalled cycle of a load so the same
   // value is seen for as long as the load stays in this stage; any change
   // of the stage register (new instruction or bubble) invalidates it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_data <= '0;
         hold_vld  <= 1'b0;
      end else if (take_bubble || take_input) begin
         hold_vld  <= 1'b0;
      end else if (is_load && !hold_vld) begin
         hold_data <= data_sram_rdata;
         hold_vld  <= 1'b1;
      end
   end

   assign rdata_sel = hold_vld ? hold_data : data_sram_rdata;

   // Pick the byte or halfword lane and extend it to 32 bits
   always_comb begin
      logic [7:0]  byte_sel;
      logic [15:0] half_sel;
      load_data = 32'h0;
      case (addr_lo_r)
         2'd0:    byte_sel = rdata_sel[7:0];
         2'd1:    byte_sel = rdata_sel[15:8];
         2'd2:    byte_sel = rdata_sel[23:16];
         default: byte_sel = rdata_sel[31:24];
      endcase
      half_sel = addr_lo_r[1] ? rdata_sel[31:16] : rdata_sel[15:0];
      case (ls_op)
         OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  load_data = {24'h0, byte_sel};
         OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  load_data = {16'h0, half_sel};
         OP_LW:   load_data = rdata_sel;
         default: load_data = 32'h0;
      endcase
   end

   assign rf_wdata = (sel_rf_res && is_load) ? load_data : ex_result;

`ifdef MEM_ADDR_ERR_EN
   // Flag misaligned halfword/word loads and block their register write
   always_comb begin
      mem_addr_err = 1'b0;
      case (ls_op)
         OP_LH, OP_LHU: mem_addr_err = addr_lo_r[0];
         OP_LW:         mem_addr_err = (addr_lo_r != 2'b00);
         default:       mem_addr_err = 1'b0;
      endcase
   end

   assign rf_we_out = rf_we && !mem_addr_err;
`else
   assign rf_we_out = rf_we;
`endif

   assign mem_to_wb_bus = {pc, rf_we_out, rf_waddr, rf_wdata,
                           hi_we, lo_we, hi, lo};

   assign mem_to_id_bus = {rf_we_out, rf_waddr, rf_wdata,
                           hi_we, lo_we, hi, lo};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed testbench for mem_stage. A vector table covers
// load extraction and pass-through; hand-written sequences cover reset,
// stall hold, bubble insertion and misaligned loads. With MEM_ADDR_ERR_EN
// defined the mem_addr_err port is connected and checked as well.

module tb_mem_stage;

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SW  = 6'b101011;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [5:0]   stall = 6'b0;
   logic [147:0] ex_to_mem_bus = '0;
   logic [1:0]   ex_addr_lo = 2'b0;
   logic [31:0]  data_sram_rdata = 32'h0;
   logic [135:0] mem_to_wb_bus;
   logic [103:0] mem_to_id_bus;
`ifdef MEM_ADDR_ERR_EN
   logic         mem_addr_err;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [5:0]  op;
      logic        sel;
      logic        sram_en;
      logic        rf_we;
      logic [1:0]  addr;
      logic [31:0] rdata;
      logic [31:0] exres;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[13];

   mem_stage dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .ex_to_mem_bus   (ex_to_mem_bus),
      .ex_addr_lo      (ex_addr_lo),
      .data_sram_rdata (data_sram_rdata),
`ifdef MEM_ADDR_ERR_EN
      .mem_addr_err    (mem_addr_err),
`endif
      .mem_to_wb_bus   (mem_to_wb_bus),
      .mem_to_id_bus   (mem_to_id_bus)
   );

   always #5 clk = ~clk;

   function automatic logic [147:0] makeBus(input logic [31:0] pc,
                                            input logic sram_en,
                                            input logic sel,
                                            input logic hi_we,
                                            input logic lo_we,
                                            input logic rf_we,
                                            input logic [4:0] waddr,
                                            input logic [5:0] op,
                                            input logic [31:0] exres,
                                            input logic [31:0] hi,
                                            input logic [31:0] lo);
      return {pc, sram_en, 4'b0000, sel, hi_we, lo_we, rf_we, waddr, op,
              exres, hi, lo};
   endfunction

   function automatic logic [135:0] expWb(input logic [31:0] pc,
                                          input logic rf_we,
                                          input logic [4:0] waddr,
                                          input logic [31:0] wdata,
                                          input logic hi_we,
                                          input logic lo_we,
                                          input logic [31:0] hi,
                                          input logic [31:0] lo);
      return {pc, rf_we, waddr, wdata, hi_we, lo_we, hi, lo};
   endfunction

   task automatic checkOutput(input string name, input logic [135:0] exp);
      logic [103:0] exp_id;
      exp_id = exp[103:0];
      checks++;
      if (mem_to_wb_bus !== exp) begin
         errors++;
         $display("[TB] FAIL %s wb got %h exp %h", name, mem_to_wb_bus, exp);
      end
      checks++;
      if (mem_to_id_bus !== exp_id) begin
         errors++;
         $display("[TB] FAIL %s id got %h exp %h", name, mem_to_id_bus, exp_id);
      end
   endtask

   task automatic checkBit(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %b exp %b", name, got, exp);
      end
   endtask

   // Load one bus into MEM with no stall, then present SRAM data
   task automatic applyStimulus(input logic [147:0] bus, input logic [1:0] addr,
                                input logic [31:0] rdata);
      ex_to_mem_bus = bus;
      ex_addr_lo    = addr;
      stall         = 6'b000000;
      @(posedge clk);
      #1;
      data_sram_rdata = rdata;
      ex_to_mem_bus   = '0;
      #1;
   endtask

   initial begin
      logic [31:0]  pc;
      logic [31:0]  hi;
      logic [31:0]  lo;
      logic [135:0] exp;

      vecs[0]  = '{OP_LB,  1'b1, 1'b1, 1'b1, 2'd3, 32'h80FF_1234, 32'h0000_0013, 32'hFFFF_FF80};
      vecs[1]  = '{OP_LBU, 1'b1, 1'b1, 1'b1, 2'd3, 32'h80FF_1234, 32'h0000_0013, 32'h0000_0080};
      vecs[2]  = '{OP_LH,  1'b1, 1'b1, 1'b1, 2'd2, 32'h8001_7FFF, 32'h0000_0022, 32'hFFFF_8001};
      vecs[3]  = '{OP_LHU, 1'b1, 1'b1, 1'b1, 2'd2, 32'h8001_7FFF, 32'h0000_0022, 32'h0000_8001};
      vecs[4]  = '{OP_LW,  1'b1, 1'b1, 1'b1, 2'd0, 32'h8001_7FFF, 32'h0000_0020, 32'h8001_7FFF};
      vecs[5]  = '{OP_LB,  1'b1, 1'b1, 1'b1, 2'd0, 32'h1234_5678, 32'h0000_0040, 32'h0000_0078};
      vecs[6]  = '{OP_LB,  1'b1, 1'b1, 1'b1, 2'd1, 32'h0000_8000, 32'h0000_0041, 32'hFFFF_FF80};
      vecs[7]  = '{OP_LBU, 1'b1, 1'b1, 1'b1, 2'd2, 32'h00AB_0000, 32'h0000_0042, 32'h0000_00AB};
      vecs[8]  = '{OP_LH,  1'b1, 1'b1, 1'b1, 2'd0, 32'h1234_F00D, 32'h0000_0050, 32'hFFFF_F00D};
      vecs[9]  = '{OP_LHU, 1'b1, 1'b1, 1'b1, 2'd0, 32'h1234_F00D, 32'h0000_0050, 32'h0000_F00D};
      vecs[10] = '{6'b000000, 1'b1, 1'b0, 1'b1, 2'd1, 32'h5555_5555, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      vecs[11] = '{OP_LW,  1'b0, 1'b1, 1'b1, 2'd0, 32'h5555_5555, 32'hCAFE_F00D, 32'hCAFE_F00D};
      vecs[12] = '{OP_SW,  1'b0, 1'b1, 1'b0, 2'd0, 32'h5555_5555, 32'h1000_0004, 32'h1000_0004};

      // Reset state while rst is held
      #2;
      checkOutput("reset_state", '0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Table-driven loads and pass-through cases
      for (int i = 0; i < 13; i++) begin
         pc = 32'h0040_0000 + 32'(i * 4);
         hi = 32'hA5A5_0000 + 32'(i);
         lo = 32'h5A5A_0000 + 32'(i);
         applyStimulus(makeBus(pc, vecs[i].sram_en, vecs[i].sel, i[0], i[1],
                               vecs[i].rf_we, 5'(i + 1), vecs[i].op,
                               vecs[i].exres, hi, lo),
                       vecs[i].addr, vecs[i].rdata);
         exp = expWb(pc, vecs[i].rf_we, 5'(i + 1), vecs[i].exp, i[0], i[1], hi, lo);
         checkOutput($sformatf("vec%0d", i), exp);
      end

      // Stall hold: LW keeps its first SRAM data for three stalled cycles
      applyStimulus(makeBus(32'h0000_0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7,
                            OP_LW, 32'h0, 32'h0, 32'h0), 2'd0, 32'h1111_1111);
      exp = expWb(32'h0000_0100, 1'b1, 5'd7, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("hold_first", exp);
      stall = 6'b011111;
      ex_to_mem_bus = makeBus(32'h0000_0200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9,
                              6'b0, 32'h9999_9999, 32'h0, 32'h0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         data_sram_rdata = 32'h2222_2222;
         #1;
         checkOutput($sformatf("hold_cyc%0d", c), exp);
      end

      // Bubble: MEM loads while only earlier stages stall, then bubbles
      stall = 6'b000111;
      ex_to_mem_bus = makeBus(32'h0000_0300, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3,
                              OP_LW, 32'h0, 32'h1234_0000, 32'h0000_5678);
      ex_addr_lo = 2'd0;
      @(posedge clk);
      #1;
      data_sram_rdata = 32'h3333_3333;
      #1;
      exp = expWb(32'h0000_0300, 1'b1, 5'd3, 32'h3333_3333, 1'b1, 1'b1,
                  32'h1234_0000, 32'h0000_5678);
      checkOutput("bubble_load", exp);
      stall = 6'b011111;
      @(posedge clk);
      #1;
      checkBit("hold_set", dut.hold_vld, 1'b1);
      stall = 6'b001111;
      @(posedge clk);
      #1;
      data_sram_rdata = 32'h4444_4444;
      #1;
      checkOutput("bubble_out", '0);
      checkBit("hold_cleared", dut.hold_vld, 1'b0);

      // Misaligned LW
      applyStimulus(makeBus(32'h0000_0400, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4,
                            OP_LW, 32'h0, 32'h0, 32'h0), 2'd2, 32'h8001_7FFF);
`ifdef MEM_ADDR_ERR_EN
      checkBit("lw_mis_err", mem_addr_err, 1'b1);
      exp = expWb(32'h0000_0400, 1'b0, 5'd4, 32'h8001_7FFF, 1'b0, 1'b0, 32'h0, 32'h0);
`else
      exp = expWb(32'h0000_0400, 1'b1, 5'd4, 32'h8001_7FFF, 1'b0, 1'b0, 32'h0, 32'h0);
`endif
      checkOutput("lw_misaligned", exp);

      // Misaligned LH uses the upper half selected by addr bit 1
      applyStimulus(makeBus(32'h0000_0404, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5,
                            OP_LH, 32'h0, 32'h0, 32'h0), 2'd3, 32'h8001_7FFF);
`ifdef MEM_ADDR_ERR_EN
      checkBit("lh_mis_err", mem_addr_err, 1'b1);
      exp = expWb(32'h0000_0404, 1'b0, 5'd5, 32'hFFFF_8001, 1'b0, 1'b0, 32'h0, 32'h0);
`else
      exp = expWb(32'h0000_0404, 1'b1, 5'd5, 32'hFFFF_8001, 1'b0, 1'b0, 32'h0, 32'h0);
`endif
      checkOutput("lh_misaligned", exp);

      // Asynchronous reset mid-cycle with rf_we=1 in MEM
      applyStimulus(makeBus(32'h0000_0500, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd6,
                            6'b0, 32'h7777_7777, 32'h1, 32'h2), 2'd0, 32'h0);
      exp = expWb(32'h0000_0500, 1'b1, 5'd6, 32'h7777_7777, 1'b1, 1'b0, 32'h1, 32'h2);
      checkOutput("pre_reset", exp);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("async_reset", '0);
`ifdef MEM_ADDR_ERR_EN
      checkBit("reset_err", mem_addr_err, 1'b0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
